hazard_ctrl_fsm: RTL
====================

Name: hazard_ctrl_fsm

Overview:
- Sequential, parametrised hazard controller for the 5-stage MIPS pipeline. It sits between IF/ID and ID/EX and drives the PC hold, IF/ID hold and ID/EX bubble-mux select.
- Detects load-use hazards and branches in ID, then holds the stall for a configurable number of cycles.
- After each stall sequence it inserts one masked release cycle, so the held instruction never re-triggers.
- Reports the hazard type and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 5, register-specifier width; rs = instr[21+REG_W-1:21], rt = instr[16+REG_W-1:16].
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (legal 1..7).
- BRANCH_STALL_CYCLES, 2, stall cycles per branch in ID (legal 1..7).
- BRANCH_EN, 1, 0 disables branch stalling.
- BEQ_OP, 6'b000100, beq opcode.
- BNE_OP, 6'b000101, bne opcode.
- SKIP_R0, 1, 1 means a destination register of 0 never causes a load-use hazard.
- CNT_W, 16, width of the stall counter.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_id_ex_mem_read  in  1  instruction in ID/EX is a load
- i_id_ex_rt  in  REG_W  load destination register in ID/EX
- i_if_id_instr  in  32  instruction held in IF/ID
- i_flush  in  1  pipeline flush (taken branch/exception); aborts any stall
- o_no_change_pc  out  1  hold PC
- o_no_change_if_id  out  1  hold IF/ID
- o_mux_selector  out  1  select zero controls into ID/EX (bubble)
- o_hazard_type  out  2  00 none, 01 load-use, 10 branch
- o_stall_count  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- States: RUN, STALL, RELEASE. A 3-bit down-counter `rem` holds the stall cycles still to issue.
- Reset (i_rst=1 at a clock edge): state is RUN, rem=0, o_stall_count=0.
- While i_rst=1, all stall outputs are forced to 0 and o_hazard_type=00.
- Load-use detect (lu): i_id_ex_mem_read && (i_id_ex_rt==rs || i_id_ex_rt==rt) && !(SKIP_R0 && i_id_ex_rt==0).
- Branch detect (br): BRANCH_EN && (opcode==BEQ_OP || opcode==BNE_OP), where opcode = i_if_id_instr[31:26].
- Priority: lu over br. If both fire, the sequence is load-use with LOAD_STALL_CYCLES only, because the branch instruction is the one held.
- RUN, no detect: all stall outputs 0, type 00.
- RUN, detect: stall outputs 1 in the same cycle (combinational, zero latency) and type is set.
  - Next state is STALL with rem=N-1 if N>1, otherwise RELEASE.
  - N = LOAD_STALL_CYCLES for lu, BRANCH_STALL_CYCLES for br.
- STALL:
  - Outputs are 1 and the registered type is held.
  - rem decrements each cycle; when rem==1 the next state is RELEASE.
  - Detection is ignored in STALL.
- RELEASE:
  - Outputs are 0 and type is 00.
  - Detection is masked for this one cycle, so the held instruction advances.
  - Next state is RUN.
- Cycle counts: total asserted stall cycles per hazard is exactly N, followed by exactly one release cycle.
- i_flush=1 in any state:
  - Outputs are forced to 0 that cycle and the next state is RUN with rem=0.
  - The flush cycle is not counted. It takes priority over detection.
- o_stall_count increments by 1 at each clock edge where o_no_change_pc=1.
  - It saturates at all-ones with no wrap.
  - It is cleared only by reset.
- The three stall outputs are always equal. They are kept as separate ports so datapath routing stays unchanged.
- Reset mid-stall: the next cycle is RUN and the outputs follow the RUN rules.

Decomposition:
- Shared package `pipe_pkg`:
  - opcode constants (BEQ_OP, BNE_OP, LW_OP);
  - hazard-type encodings (HZ_NONE, HZ_LOAD, HZ_BRANCH);
  - state encodings (ST_RUN, ST_STALL, ST_RELEASE).
- One natural sub-module, `sat_counter`: parametrised by CNT_W, with i_clk, i_rst, i_inc and o_count. It is reused later for other pipeline performance counters.

Test Plan:
- Load-use: ID/EX has lw with rt=8 (mem_read=1); IF/ID has add with rs=8 (instr 0x01095020) -> stall=1 for 1 cycle, type 01; next cycle RELEASE with outputs 0; stall_count=1.
- Branch multi-cycle (BRANCH_STALL_CYCLES=2): IF/ID holds beq 0x11090003 with no load ahead -> stall=1 for 2 cycles, type 10, then 1 release cycle at 0; stall_count=2. With BNE_OP 0x15090003 -> same result. With BRANCH_EN=0 -> no stall.
- Priority: lw with rt=9 in ID/EX and beq using rt=9 in IF/ID -> type 01, 1 stall cycle only, then release, and no follow-on branch stall for the same instruction.
- R0 skip: lw with rt=0 and IF/ID rs=0 -> no stall with SKIP_R0=1; 1 stall cycle with SKIP_R0=0.
- Flush mid-sequence: LOAD_STALL_CYCLES=3, assert i_flush in the 2nd stall cycle -> outputs 0 that cycle, state RUN next; stall_count=1.
- Saturation/reset: CNT_W=4, 20 back-to-back branch hazards -> stall_count stops at 15. Assert i_rst in a STALL cycle -> outputs 0 and count 0 after the edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, hazard-type encodings and hazard FSM states.
package pipe_pkg;

  localparam logic [5:0] BEQ_OP = 6'b000100;
  localparam logic [5:0] BNE_OP = 6'b000101;
  localparam logic [5:0] LW_OP  = 6'b100011;

  typedef enum logic [1:0] {
    HZ_NONE   = 2'b00,
    HZ_LOAD   = 2'b01,
    HZ_BRANCH = 2'b10
  } hz_type_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_STALL   = 2'b01,
    ST_RELEASE = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fsm_if.sv
// Pipeline-side view of the hazard controller: ID/EX and IF/ID taps in, stall controls out.
interface hazard_ctrl_fsm_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             i_id_ex_mem_read;
  logic [REG_W-1:0] i_id_ex_rt;
  logic [31:0]      i_if_id_instr;
  logic             i_flush;
  logic             o_no_change_pc;
  logic             o_no_change_if_id;
  logic             o_mux_selector;
  logic [1:0]       o_hazard_type;
  logic [CNT_W-1:0] o_stall_count;

  modport master (
    output i_id_ex_mem_read, i_id_ex_rt, i_if_id_instr, i_flush,
    input  o_no_change_pc, o_no_change_if_id, o_mux_selector, o_hazard_type, o_stall_count
  );

  modport slave (
    input  i_id_ex_mem_read, i_id_ex_rt, i_if_id_instr, i_flush,
    output o_no_change_pc, o_no_change_if_id, o_mux_selector, o_hazard_type, o_stall_count
  );
endinterface

// File: rtl/hazard_ctrl_fsm_sat_counter.sv
// Saturating up-counter for pipeline performance statistics; cleared only by reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  always_ff @(posedge i_clk) begin
    if (i_rst)                        o_count <= '0;
    else if (i_inc && (o_count != '1)) o_count <= o_count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl_fsm.sv
// Load-use / branch hazard controller between IF/ID and ID/EX with N-cycle stall,
// one masked release cycle and a saturating stall-cycle counter.
module hazard_ctrl_fsm
  import pipe_pkg::*;
#(
  parameter int         REG_W               = 5,
  parameter int         LOAD_STALL_CYCLES   = 1,
  parameter int         BRANCH_STALL_CYCLES = 2,
  parameter bit         BRANCH_EN           = 1'b1,
  parameter logic [5:0] BEQ_OP              = pipe_pkg::BEQ_OP,
  parameter logic [5:0] BNE_OP              = pipe_pkg::BNE_OP,
  parameter bit         SKIP_R0             = 1'b1,
  parameter int         CNT_W               = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  hazard_ctrl_fsm_if.slave bus
);

  localparam logic [2:0] LOAD_REM   = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] BRANCH_REM = 3'(BRANCH_STALL_CYCLES - 1);

  hz_state_e        state;
  hz_type_e         type_q;
  logic [2:0]       rem;
  logic [REG_W-1:0] rs, rt;
  logic [5:0]       opcode;
  logic             lu, br, stall;
  hz_type_e         hz_type;

  assign rs     = bus.i_if_id_instr[21 +: REG_W];
  assign rt     = bus.i_if_id_instr[16 +: REG_W];
  assign opcode = bus.i_if_id_instr[31:26];

  assign lu = bus.i_id_ex_mem_read
           && ((bus.i_id_ex_rt == rs) || (bus.i_id_ex_rt == rt))
           && !(SKIP_R0 && (bus.i_id_ex_rt == '0));
  assign br = BRANCH_EN && ((opcode == BEQ_OP) || (opcode == BNE_OP));

  // Detection acts in the same cycle it fires, so the RUN outputs are combinational.
  always_comb begin
    stall   = 1'b0;
    hz_type = HZ_NONE;
    if (!i_rst && !bus.i_flush) begin
      case (state)
        ST_RUN: begin
          if (lu) begin
            stall   = 1'b1;
            hz_type = HZ_LOAD;
          end else if (br) begin
            stall   = 1'b1;
            hz_type = HZ_BRANCH;
          end
        end
        ST_STALL: begin
          stall   = 1'b1;
          hz_type = type_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush) begin
      state  <= ST_RUN;
      rem    <= '0;
      if (i_rst) type_q <= HZ_NONE;
    end else begin
      case (state)
        ST_RUN: begin
          if (lu) begin
            type_q <= HZ_LOAD;
            rem    <= LOAD_REM;
            state  <= (LOAD_REM != 3'd0) ? ST_STALL : ST_RELEASE;
          end else if (br) begin
            type_q <= HZ_BRANCH;
            rem    <= BRANCH_REM;
            state  <= (BRANCH_REM != 3'd0) ? ST_STALL : ST_RELEASE;
          end
        end
        ST_STALL: begin
          rem <= rem - 3'd1;
          if (rem == 3'd1) state <= ST_RELEASE;
        end
        // Held instruction advances here with detection masked.
        ST_RELEASE: state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  assign bus.o_no_change_pc    = stall;
  assign bus.o_no_change_if_id = stall;
  assign bus.o_mux_selector    = stall;
  assign bus.o_hazard_type     = hz_type;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (stall),
    .o_count (bus.o_stall_count)
  );

endmodule
